fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_pkg.sv | 16 +
 rtl/rr_picker.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO write-side arbiter:
//   arb_state_t   - arbiter FSM encoding (IDLE, GRANT)
//   DEFAULT_BURST - default maximum beats accepted per grant
// ----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEFAULT_BURST = 4;

endpackage : fifo_pkg

// File: rtl/rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. It scans the request vector starting at
// ptr and wrapping modulo nreq. It returns the first set position.
// Ports:
//   req   [nreq-1:0]          request vector
//   ptr   [$clog2(nreq)-1:0]  position to start scanning from
//   found                     at least one request is set
//   index [$clog2(nreq)-1:0]  first requesting position at or after ptr
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int nreq = 4
) (
    input  logic [nreq-1:0]         req,
    input  logic [$clog2(nreq)-1:0] ptr,
    output logic                    found,
    output logic [$clog2(nreq)-1:0] index
);

    localparam int IW = $clog2(nreq);

    logic [IW-1:0] cand_s;

    // Scan from the farthest offset back towards ptr. The nearest requester is
    // therefore the last one written and wins.
    always_comb begin
        found  = 1'b0;
        index  = '0;
        cand_s = '0;
        for (int k = nreq - 1; k >= 0; k--) begin
            cand_s = IW'((int'(ptr) + k) % nreq);
            found  = found | req[cand_s];
            index  = req[cand_s] ? cand_s : index;
        end
    end

endmodule : rr_picker

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter that funnels nreq valid/ready requesters into a single
// FIFO write port. A grant accepts at most `burst` beats. A grant ends early
// when the grantee drops valid. Every grant is preceded by one IDLE cycle.
// Ports:
//   clk        FIFO write clock
//   rst        asynchronous active-high reset
//   req_valid  per-requester data valid
//   req_data   packed requester data, requester i at [i*width +: width]
//   req_ready  per-requester accept strobe (combinational)
//   full       FIFO full flag (registered in the write domain)
//   wen        FIFO write enable (registered)
//   wdata      FIFO write data (registered)
//   grant_id   index of the current or most recent grantee
//   busy       high while a grant is active
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int width = 8,
    parameter int nreq  = 4,
    parameter int burst = DEFAULT_BURST
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [nreq-1:0]         req_valid,
    input  logic [nreq*width-1:0]   req_data,
    output logic [nreq-1:0]         req_ready,
    input  logic                    full,
    output logic                    wen,
    output logic [width-1:0]        wdata,
    output logic [$clog2(nreq)-1:0] grant_id,
    output logic                    busy
);

    localparam int IW = $clog2(nreq);
    localparam int BW = $clog2(burst) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(burst - 1);

    arb_state_t       state_r;
    logic [IW-1:0]    rr_ptr_r;
    logic [IW-1:0]    grant_id_r;
    logic [BW-1:0]    beat_cnt_r;
    logic             wen_r;
    logic [width-1:0] wdata_r;

    logic             pick_found_s;
    logic [IW-1:0]    pick_idx_s;
    logic             grant_valid_s;
    logic             accept_s;
    logic [IW-1:0]    next_ptr_s;
    logic [width-1:0] sel_data_s;
    logic [nreq-1:0]  ready_s;

    rr_picker #(
        .nreq (nreq)
    ) u_rr_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .found (pick_found_s),
        .index (pick_idx_s)
    );

    assign grant_valid_s = req_valid[grant_id_r];
    // full only stalls the grant. A valid drop is still seen, so it can end the grant.
    assign accept_s      = (state_r == GRANT) & grant_valid_s & ~full;
    assign next_ptr_s    = (grant_id_r == IW'(nreq - 1)) ? '0 : grant_id_r + IW'(1);

    // Data mux for the current grantee.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < nreq; i++) begin
            sel_data_s = (grant_id_r == IW'(i)) ? req_data[i*width +: width] : sel_data_s;
        end
    end

    // Ready is one-hot on the grantee. It is held low while the FIFO is full.
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < nreq; i++) begin
            ready_s[i] = (state_r == GRANT) & ~full & (grant_id_r == IW'(i));
        end
    end

    // Arbitration FSM, burst accounting and the registered FIFO write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            grant_id_r <= '0;
            beat_cnt_r <= '0;
            wen_r      <= 1'b0;
            wdata_r    <= '0;
        end else begin
            wen_r <= accept_s;
            if (accept_s) begin
                wdata_r <= sel_data_s;
            end
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        grant_id_r <= pick_idx_s;
                        beat_cnt_r <= '0;
                        state_r    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!grant_valid_s) begin
                        state_r  <= IDLE;
                        rr_ptr_r <= next_ptr_s;
                    end else if (accept_s) begin
                        beat_cnt_r <= beat_cnt_r + BW'(1);
                        if (beat_cnt_r == LAST_BEAT) begin
                            state_r  <= IDLE;
                            rr_ptr_r <= next_ptr_s;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_s;
    assign wen       = wen_r;
    assign wdata     = wdata_r;
    assign grant_id  = grant_id_r;
    assign busy      = (state_r == GRANT);

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed self-checking bench for fifo_wr_arbiter (width=8, nreq=4, burst=4).
// Each requester's data advances by one after every edge where it was accepted.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int W = 8;
    localparam int N = 4;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [7:0]     data [N];
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           full;
    logic           wen;
    logic [W-1:0]   wdata;
    logic [1:0]     grant_id;
    logic           busy;

    int n_cmp = 0;
    int n_mis = 0;
    int served [N];

    always #5 clk = ~clk;

    assign req_data = {data[3], data[2], data[1], data[0]};

    fifo_wr_arbiter #(
        .width (W),
        .nreq  (N),
        .burst (B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .wen       (wen),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: note who gets accepted, pass the edge, then advance that data.
    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) data[i] = data[i] + 8'd1;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        full      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) data[i] = 8'h00;
        rst       = 1'b1;
        req_valid = 4'b0000;
        full      = 1'b0;
        tick();
        tick();
        chk("rst_wen",   32'(wen),       32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_gid",   32'(grant_id),  32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wdata", 32'(wdata),     32'd0);
        rst = 1'b0;

        // Single requester, 6 beats: 4-beat burst, IDLE bubble, then 2 more
        data[0]   = 8'h10;
        req_valid = 4'b0001;
        tick();
        chk("s_busy",  32'(busy),      32'd1);
        chk("s_gid",   32'(grant_id),  32'd0);
        chk("s_wen0",  32'(wen),       32'd0);
        chk("s_ready", 32'(req_ready), 32'd1);
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("s_wen",   32'(wen),   32'd1);
            chk("s_wdata", 32'(wdata), 32'h10 + 32'(b));
        end
        chk("s_busy_end",  32'(busy),      32'd0);
        chk("s_ready_end", 32'(req_ready), 32'd0);
        tick();
        chk("s_bubble_wen",  32'(wen),      32'd0);
        chk("s_bubble_busy", 32'(busy),     32'd1);
        chk("s_bubble_gid",  32'(grant_id), 32'd0);
        tick();
        chk("s_wen4",   32'(wen),   32'd1);
        chk("s_wdata4", 32'(wdata), 32'h14);
        tick();
        chk("s_wen5",   32'(wen),   32'd1);
        chk("s_wdata5", 32'(wdata), 32'h15);
        req_valid = 4'b0000;
        tick();
        chk("s_drop_wen",  32'(wen),  32'd0);
        chk("s_drop_busy", 32'(busy), 32'd0);

        // All requesters valid: grants 0,1,2,3,0 with 4 beats each
        do_reset();
        for (int i = 0; i < N; i++) begin
            data[i]   = 8'(i << 4);
            served[i] = 0;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_busy",   32'(busy),     32'd1);
            chk("rr_gid",    32'(grant_id), 32'(k % N));
            chk("rr_bubble", 32'(wen),      32'd0);
            for (int b = 0; b < 4; b++) begin
                tick();
                chk("rr_wen",   32'(wen),   32'd1);
                chk("rr_wdata", 32'(wdata), 32'(((k % N) << 4) + served[k % N]));
                chk("rr_busyb", 32'(busy),  (b < 3) ? 32'd1 : 32'd0);
                served[k % N]++;
            end
        end
        req_valid = 4'b0000;

        // full raised for 3 cycles mid-burst
        do_reset();
        data[0]   = 8'h20;
        req_valid = 4'b0001;
        tick();
        tick();
        chk("f_wdata0", 32'(wdata), 32'h20);
        tick();
        chk("f_wdata1", 32'(wdata), 32'h21);
        full = 1'b1;
        #1;
        chk("f_ready_low", 32'(req_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("f_stall_wen",  32'(wen),      32'd0);
            chk("f_stall_busy", 32'(busy),     32'd1);
            chk("f_stall_gid",  32'(grant_id), 32'd0);
        end
        full = 1'b0;
        #1;
        chk("f_ready_back", 32'(req_ready), 32'd1);
        tick();
        chk("f_wen2",   32'(wen),   32'd1);
        chk("f_wdata2", 32'(wdata), 32'h22);
        req_valid = 4'b0001;
        tick();
        chk("f_wen3",   32'(wen),   32'd1);
        chk("f_wdata3", 32'(wdata), 32'h23);
        chk("f_done",   32'(busy),  32'd0);
        req_valid = 4'b0000;

        // Grantee drops after 2 beats while requester 2 waits
        do_reset();
        data[0]   = 8'h30;
        data[2]   = 8'h50;
        req_valid = 4'b0101;
        tick();
        chk("d_gid0", 32'(grant_id), 32'd0);
        tick();
        chk("d_wdata0", 32'(wdata), 32'h30);
        tick();
        chk("d_wdata1", 32'(wdata), 32'h31);
        req_valid = 4'b0100;
        tick();
        chk("d_exit_busy", 32'(busy), 32'd0);
        chk("d_exit_wen",  32'(wen),  32'd0);
        req_valid = 4'b0101;
        tick();
        chk("d_next_busy", 32'(busy),     32'd1);
        chk("d_next_gid",  32'(grant_id), 32'd2);
        tick();
        chk("d_next_wen",   32'(wen),   32'd1);
        chk("d_next_wdata", 32'(wdata), 32'h50);
        req_valid = 4'b0000;

        // full and valid drop in the same cycle
        do_reset();
        data[1]   = 8'h60;
        req_valid = 4'b0010;
        tick();
        chk("fd_gid", 32'(grant_id), 32'd1);
        tick();
        chk("fd_wdata", 32'(wdata), 32'h60);
        full      = 1'b1;
        req_valid = 4'b0000;
        tick();
        chk("fd_busy", 32'(busy), 32'd0);
        chk("fd_wen",  32'(wen),  32'd0);
        tick();
        chk("fd_wen2",  32'(wen),  32'd0);
        chk("fd_busy2", 32'(busy), 32'd0);
        full = 1'b0;

        // Asynchronous reset mid-burst
        do_reset();
        data[1]   = 8'h70;
        req_valid = 4'b0010;
        tick();
        tick();
        tick();
        chk("ar_pre_wdata", 32'(wdata), 32'h71);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_wen",   32'(wen),       32'd0);
        chk("ar_busy",  32'(busy),      32'd0);
        chk("ar_gid",   32'(grant_id),  32'd0);
        chk("ar_ready", 32'(req_ready), 32'd0);
        chk("ar_wdata", 32'(wdata),     32'd0);
        req_valid = 4'b0011;
        data[0]   = 8'h40;
        tick();
        chk("ar_hold_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("ar_rel_busy", 32'(busy),     32'd1);
        chk("ar_rel_gid",  32'(grant_id), 32'd0);
        tick();
        chk("ar_rel_wen",   32'(wen),   32'd1);
        chk("ar_rel_wdata", 32'(wdata), 32'h40);
        req_valid = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
